mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be synchronous and active-high; ports are named Clk and Reset.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous active-high reset, sampled on rising Clk.
REQ-004 Start  input  1  operation request, sampled on rising Clk.
REQ-005 Op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 A  input  32  rs operand (multiplicand / dividend).
REQ-007 B  input  32  rt operand (multiplier / divisor).
REQ-008 Busy  output  1  high while an operation is in progress.
REQ-009 WriteEnable  output  1  one-cycle result strobe; drives the HiLo register write enable.
REQ-010 WriteData  output  64  result {Hi[63:32], Lo[31:0]}; drives the HiLo register write data.

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE.
- IDLE -> RUN on Start=1.
- RUN -> DONE after exactly 32 RUN cycles.
- DONE -> IDLE unconditionally.
REQ-012 Start SHALL be accepted only in IDLE; in RUN or DONE it SHALL be ignored with no effect on the operation in flight.
REQ-013 On acceptance, the block SHALL latch Op, A and B; later changes on these inputs SHALL NOT affect the result.
REQ-014 Signed ops (MULT, DIV) SHALL run on operand magnitudes; magnitude of 0x80000000 is 2^31 (unsigned 32-bit, no overflow).
REQ-015 RUN SHALL perform one iteration per cycle, driven by a 5-bit iteration counter:
- multiply: shift-add;
- divide: restoring shift-subtract.
REQ-016 Multiply result SHALL be the full 64-bit product; for MULT it is negated when sign(A) XOR sign(B) = 1.
REQ-017 Divide result SHALL be Lo = quotient, Hi = remainder, truncating toward zero.
- DIV quotient is negated when sign(A) XOR sign(B) = 1.
- DIV remainder takes the sign of A.
REQ-018 DIV 0x80000000 / 0xFFFFFFFF SHALL give Lo = 0x80000000, Hi = 0x00000000.
REQ-019 When B = 0 on DIV or DIVU, the result SHALL be Lo = 0xFFFFFFFF, Hi = latched A (raw), with no sign correction; latency is unchanged.
REQ-020 Sign correction SHALL be applied on entry to DONE.
REQ-021 WriteData SHALL be registered, updated only on entry to DONE, and held until the next DONE or Reset.
REQ-022 Timing for Start accepted at rising edge k:
- Busy = 1 in cycles k+1 .. k+33;
- WriteEnable = 1 only in cycle k+33 (DONE);
- Busy = 0 from cycle k+34;
- total latency is 33 cycles.
REQ-023 WriteEnable SHALL be high for one full Clk period, so a downstream register that writes on the falling Clk edge samples it exactly once.
REQ-024 A new Start SHALL be accepted in the first IDLE cycle after DONE (cycle k+34), giving back-to-back throughput of one result per 34 cycles.

Reset
REQ-025 Reset=1 at a rising Clk edge SHALL force, from the next cycle:
- state IDLE;
- Busy = 0;
- WriteEnable = 0;
- WriteData = 0;
- iteration counter and internal operand/accumulator registers = 0.
REQ-026 Reset SHALL override Start in the same cycle.
REQ-027 Reset during RUN or DONE SHALL abort the operation with no WriteEnable pulse after the Reset edge.
REQ-028 Power-up state before the first Reset SHALL NOT be relied on.

Verification
REQ-029 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> WriteData = 0xFFFFFFFE_00000001; WriteEnable high only at k+33.
REQ-030 MULT A=0xFFFFFFFD (-3), B=0x00000007 -> WriteData = 0xFFFFFFFF_FFFFFFEB.
REQ-031 DIV A=0xFFFFFFF9 (-7), B=0x00000002 -> Hi = 0xFFFFFFFF, Lo = 0xFFFFFFFD.
REQ-032 DIVU A=0x00000064, B=0 -> Hi = 0x00000064, Lo = 0xFFFFFFFF.
REQ-033 DIV A=0x80000000, B=0xFFFFFFFF -> WriteData = 0x00000000_80000000.
REQ-034 Start MULTU 5*6 with a second Start pulsed at k+5, then Reset at k+10 -> Busy = 0 from k+11, no WriteEnable pulse, WriteData = 0; a fresh MULTU 5*6 started after the Reset -> WriteData = 0x00000000_0000001E.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32x32 mult/div; in Clk,Reset,Start,Op,A,B; out Busy,WriteEnable,WriteData{Hi,Lo}
module mult_div_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        WriteEnable,
  output logic [63:0] WriteData
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic [31:0] a_q, a_d, m_q, m_d;
  logic [63:0] p_q, p_d, wd_q, wd_d;
  logic [31:0] mag_a, mag_b, q_fix, r_fix;
  logic [32:0] sum, t, diff;
  logic [63:0] step, fix;
  always_comb begin
    mag_a = (~Op[0] & A[31]) ? -A : A;
    mag_b = (~Op[0] & B[31]) ? -B : B;
    sum   = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, m_q} : 33'd0);
    t     = {p_q[63:32], p_q[31]};
    diff  = t - {1'b0, m_q};
    step  = op_q[1] ? (diff[32] ? {t[31:0], p_q[30:0], 1'b0} : {diff[31:0], p_q[30:0], 1'b1})
                    : {sum, p_q[31:1]};
    q_fix = (sa_q ^ sb_q) ? -step[31:0] : step[31:0];
    r_fix = sa_q ? -step[63:32] : step[63:32];
    fix   = !op_q[1] ? ((sa_q ^ sb_q) ? -step : step)
                     : (m_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {r_fix, q_fix};
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    a_d     = a_q;
    m_d     = m_q;
    p_d     = p_q;
    wd_d    = wd_q;
    if (state_q == IDLE && Start) begin
      state_d = RUN;
      cnt_d   = 5'd0;
      op_d    = Op;
      sa_d    = ~Op[0] & A[31];
      sb_d    = ~Op[0] & B[31];
      a_d     = A;
      m_d     = Op[1] ? mag_b : mag_a;
      p_d     = {32'd0, Op[1] ? mag_a : mag_b};
    end else if (state_q == RUN) begin
      p_d   = step;
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        state_d = DONE;
        wd_d    = fix;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 2'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      a_q     <= 32'd0;
      m_q     <= 32'd0;
      p_q     <= 64'd0;
      wd_q    <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      a_q     <= a_d;
      m_q     <= m_d;
      p_q     <= p_d;
      wd_q    <= wd_d;
    end
  end
  assign Busy        = state_q != IDLE;
  assign WriteEnable = state_q == DONE;
  assign WriteData   = wd_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic [1:0]  Op;
  logic [31:0] A, B;
  logic        Busy, WriteEnable;
  logic [63:0] WriteData;
  int compared = 0;
  int mismatched = 0;
  mult_div_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .WriteEnable(WriteEnable), .WriteData(WriteData)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    Start = 1'b1;
    Op = op;
    A = a;
    B = b;
    @(negedge Clk);
    Start = 1'b0;
    A = ~a;
    B = b ^ 32'h5A5A_0001;
    Op = ~op;
    for (int n = 1; n <= 34; n++) begin
      if (n > 1) @(negedge Clk);
      check($sformatf("%s busy k+%0d", name, n), {63'd0, Busy}, {63'd0, n <= 33});
      check($sformatf("%s we k+%0d", name, n), {63'd0, WriteEnable}, {63'd0, n == 33});
      if (n == 33) check($sformatf("%s data", name), WriteData, exp);
      if (n == 34) check($sformatf("%s data held", name), WriteData, exp);
      Start = (n == 5) || (n == 33);
    end
    Start = 1'b0;
  endtask
  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Op = 2'd0;
    A = 32'd0;
    B = 32'd0;
    @(negedge Clk);
    @(negedge Clk);
    check("reset busy", {63'd0, Busy}, 64'd0);
    check("reset we", {63'd0, WriteEnable}, 64'd0);
    check("reset data", WriteData, 64'd0);
    Start = 1'b1;
    Op = 2'b01;
    A = 32'd3;
    B = 32'd4;
    @(negedge Clk);
    check("reset over start", {63'd0, Busy}, 64'd0);
    Reset = 1'b0;
    Start = 1'b0;
    @(negedge Clk);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_by0", 2'b11, 32'h0000_0064, 32'h0000_0000, 64'h0000_0064_FFFF_FFFF);
    run_op("div_minbyneg1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    run_op("mult_minxmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("divu_100by7", 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    run_op("div_7byneg2", 2'b10, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
    run_op("div_neg5by0", 2'b10, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF);
    run_op("mult_neg1sq", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    Start = 1'b1;
    Op = 2'b01;
    A = 32'd5;
    B = 32'd6;
    @(negedge Clk);
    Start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge Clk);
      check($sformatf("abort busy k+%0d", n), {63'd0, Busy}, {63'd0, n <= 10});
      check($sformatf("abort we k+%0d", n), {63'd0, WriteEnable}, 64'd0);
      if (n >= 11) check($sformatf("abort data k+%0d", n), WriteData, 64'd0);
      Start = (n == 5);
      Reset = (n == 10);
    end
    Start = 1'b0;
    Reset = 1'b0;
    run_op("multu_5x6", 2'b01, 32'd5, 32'd6, 64'h0000_0000_0000_001E);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
